// File: rtl/rx_resp_tracker.sv
// rtl/rx_resp_tracker.sv - per-instance response tracking with timeout and in-order host return
// Each switch instance owns one slot; DONE slots drain to the host lowest index first.
module rx_resp_tracker #(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           issue_valid,
  input  logic [2:0]                     issue_sw,
  input  logic                           issue_wr_rd,
  input  logic [7:0]                     issue_op_id,
  input  logic [NUM_SW_INST-1:0]         ack_in,
  input  logic [NUM_SW_INST*W_WIDTH-1:0] sw_rd_data,
  output logic [NUM_SW_INST-1:0]         sw_busy,
  output logic                           issue_err,
  output logic                           ready,
  output logic [7:0]                     ready_id,
  output logic [W_WIDTH-1:0]             rd_data_out,
  output logic                           resp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } slot_state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  localparam bit         TO_EN   = (TIMEOUT_CYC != 0);

  slot_state_e          state_q [NUM_SW_INST];
  slot_state_e          state_d [NUM_SW_INST];
  logic [7:0]           id_q    [NUM_SW_INST];
  logic [7:0]           id_d    [NUM_SW_INST];
  logic                 wr_q    [NUM_SW_INST];
  logic                 wr_d    [NUM_SW_INST];
  logic                 err_q   [NUM_SW_INST];
  logic                 err_d   [NUM_SW_INST];
  logic [W_WIDTH-1:0]   data_q  [NUM_SW_INST];
  logic [W_WIDTH-1:0]   data_d  [NUM_SW_INST];
  logic [7:0]           cnt_q   [NUM_SW_INST];
  logic [7:0]           cnt_d   [NUM_SW_INST];

  logic [NUM_SW_INST-1:0] issue_hit;
  logic [NUM_SW_INST-1:0] grant;
  logic                   grant_found;

  logic               issue_err_q, issue_err_d;
  logic               ready_q, ready_d;
  logic [7:0]         ready_id_q, ready_id_d;
  logic [W_WIDTH-1:0] rd_data_q, rd_data_d;
  logic               resp_err_q, resp_err_d;

  // Out-of-range indices never match a slot, so they fall into issue_err too.
  always_comb begin
    issue_hit = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      issue_hit[i] = issue_valid && (issue_sw == 3'(i)) && (state_q[i] == S_IDLE);
    end
    issue_err_d = issue_valid && (issue_hit == '0);
  end

  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      if (state_q[i] == S_DONE && !grant_found) begin
        grant[i]    = 1'b1;
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    ready_d    = grant_found;
    ready_id_d = ready_id_q;
    rd_data_d  = rd_data_q;
    resp_err_d = resp_err_q;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      if (grant[i]) begin
        ready_id_d = id_q[i];
        rd_data_d  = data_q[i];
        resp_err_d = err_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SW_INST; i++) begin
      state_d[i] = state_q[i];
      id_d[i]    = id_q[i];
      wr_d[i]    = wr_q[i];
      err_d[i]   = err_q[i];
      data_d[i]  = data_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        S_IDLE: begin
          if (issue_hit[i]) begin
            state_d[i] = S_WAIT;
            id_d[i]    = issue_op_id;
            wr_d[i]    = issue_wr_rd;
            err_d[i]   = 1'b0;
            cnt_d[i]   = 8'd0;
          end
        end
        S_WAIT: begin
          // Ack is checked first so it wins a tie with the final timeout cycle.
          if (ack_in[i]) begin
            state_d[i] = S_DONE;
            err_d[i]   = 1'b0;
            data_d[i]  = wr_q[i] ? '0 : sw_rd_data[i*W_WIDTH +: W_WIDTH];
          end else if (TO_EN && cnt_q[i] == TO_LAST) begin
            state_d[i] = S_DONE;
            err_d[i]   = 1'b1;
            data_d[i]  = '0;
          end else if (TO_EN) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
        end
        S_DONE: begin
          if (grant[i]) begin
            state_d[i] = S_IDLE;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_SW_INST; i++) begin
        state_q[i] <= S_IDLE;
        id_q[i]    <= 8'd0;
        wr_q[i]    <= 1'b0;
        err_q[i]   <= 1'b0;
        data_q[i]  <= '0;
        cnt_q[i]   <= 8'd0;
      end
      issue_err_q <= 1'b0;
      ready_q     <= 1'b0;
      ready_id_q  <= 8'd0;
      rd_data_q   <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SW_INST; i++) begin
        state_q[i] <= state_d[i];
        id_q[i]    <= id_d[i];
        wr_q[i]    <= wr_d[i];
        err_q[i]   <= err_d[i];
        data_q[i]  <= data_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      issue_err_q <= issue_err_d;
      ready_q     <= ready_d;
      ready_id_q  <= ready_id_d;
      rd_data_q   <= rd_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  always_comb begin
    sw_busy = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      sw_busy[i] = (state_q[i] != S_IDLE);
    end
  end

  assign issue_err   = issue_err_q;
  assign ready       = ready_q;
  assign ready_id    = ready_id_q;
  assign rd_data_out = rd_data_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_rx_resp_tracker.sv
// tb/tb_rx_resp_tracker.sv - directed bench for rx_resp_tracker with a timestamp-based reference model
// The model tracks outstanding ops by issue time and deadline; a negedge process compares every cycle.
module tb_rx_resp_tracker;
  localparam int NSW = 5;
  localparam int W   = 8;
  localparam int TO  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           issue_valid;
  logic [2:0]     issue_sw;
  logic           issue_wr_rd;
  logic [7:0]     issue_op_id;
  logic [NSW-1:0] ack_in;
  logic [NSW*W-1:0] sw_rd_data;
  logic [NSW-1:0] sw_busy;
  logic           issue_err;
  logic           ready;
  logic [7:0]     ready_id;
  logic [W-1:0]   rd_data_out;
  logic           resp_err;

  int checks = 0;
  int errors = 0;

  rx_resp_tracker #(.NUM_SW_INST(NSW), .W_WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_sw(issue_sw),
    .issue_wr_rd(issue_wr_rd), .issue_op_id(issue_op_id), .ack_in(ack_in),
    .sw_rd_data(sw_rd_data), .sw_busy(sw_busy), .issue_err(issue_err),
    .ready(ready), .ready_id(ready_id), .rd_data_out(rd_data_out), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: an op is outstanding from its issue edge until ack or its deadline edge.
  int             cyc = 0;
  bit             mvalid = 1'b0;
  bit             m_wait [NSW];
  bit             m_done [NSW];
  bit             m_wr   [NSW];
  bit             m_err  [NSW];
  logic [7:0]     m_id   [NSW];
  logic [W-1:0]   m_data [NSW];
  int             m_deadline [NSW];
  logic [NSW-1:0] exp_busy;
  logic           exp_ready, exp_ierr, exp_err;
  logic [7:0]     exp_id;
  logic [W-1:0]   exp_data;

  always @(posedge clk) begin
    int acc;
    int g;
    cyc = cyc + 1;
    if (rst_n) begin
      mvalid = 1'b1;
      for (int i = 0; i < NSW; i++) begin
        m_wait[i] = 1'b0;
        m_done[i] = 1'b0;
      end
      exp_ready = 1'b0; exp_ierr = 1'b0; exp_err = 1'b0;
      exp_id = 8'd0; exp_data = '0;
    end else begin
      acc = -1;
      if (issue_valid && int'(issue_sw) < NSW && !m_wait[issue_sw] && !m_done[issue_sw])
        acc = int'(issue_sw);
      exp_ierr = issue_valid && (acc < 0);
      g = -1;
      for (int i = 0; i < NSW; i++)
        if (m_done[i] && g < 0) g = i;
      exp_ready = (g >= 0);
      if (g >= 0) begin
        exp_id   = m_id[g];
        exp_data = m_data[g];
        exp_err  = m_err[g];
        m_done[g] = 1'b0;
      end
      for (int i = 0; i < NSW; i++) begin
        if (m_wait[i]) begin
          if (ack_in[i]) begin
            m_wait[i] = 1'b0; m_done[i] = 1'b1; m_err[i] = 1'b0;
            m_data[i] = m_wr[i] ? '0 : sw_rd_data[i*W +: W];
          end else if (TO != 0 && cyc >= m_deadline[i]) begin
            m_wait[i] = 1'b0; m_done[i] = 1'b1; m_err[i] = 1'b1;
            m_data[i] = '0;
          end
        end
      end
      if (acc >= 0) begin
        m_wait[acc] = 1'b1;
        m_id[acc] = issue_op_id;
        m_wr[acc] = issue_wr_rd;
        m_deadline[acc] = cyc + TO;
      end
    end
    for (int i = 0; i < NSW; i++) exp_busy[i] = m_wait[i] | m_done[i];
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_busy", 32'(sw_busy), 32'(exp_busy));
      chk("model_ready", 32'(ready), 32'(exp_ready));
      chk("model_issue_err", 32'(issue_err), 32'(exp_ierr));
      chk("model_ready_id", 32'(ready_id), 32'(exp_id));
      if (exp_ready) begin
        chk("model_rd_data", 32'(rd_data_out), 32'(exp_data));
        chk("model_resp_err", 32'(resp_err), 32'(exp_err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    ack_in = '0;
  endtask

  task automatic issue(input int sw, input logic wr, input logic [7:0] id);
    issue_valid = 1'b1;
    issue_sw = 3'(sw);
    issue_wr_rd = wr;
    issue_op_id = id;
  endtask

  task automatic set_data(input int sw, input logic [7:0] v);
    sw_rd_data[sw*W +: W] = v;
  endtask

  task automatic chk_resp(input string name, input logic [7:0] id, input logic [7:0] d, input logic e);
    chk({name, "_ready"}, 32'(ready), 32'd1);
    chk({name, "_id"}, 32'(ready_id), 32'(id));
    chk({name, "_data"}, 32'(rd_data_out), 32'(d));
    chk({name, "_err"}, 32'(resp_err), 32'(e));
  endtask

  initial begin
    rst_n = 1'b1; issue_valid = 1'b0; issue_sw = '0; issue_wr_rd = 1'b0;
    issue_op_id = '0; ack_in = '0; sw_rd_data = '0;
    tick(); tick();
    chk("rst_busy", 32'(sw_busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_id", 32'(ready_id), 32'd0);
    chk("rst_data", 32'(rd_data_out), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_ierr", 32'(issue_err), 32'd0);
    rst_n = 1'b0;
    tick();

    // Single read on sw 2
    issue(2, 1'b0, 8'h11); tick();
    chk("rd_busy", 32'(sw_busy), 32'b00100);
    tick(); tick();
    ack_in = 5'b00100; set_data(2, 8'hA5); tick();
    chk("rd_not_yet", 32'(ready), 32'd0);
    tick();
    chk_resp("rd", 8'h11, 8'hA5, 1'b0);
    chk("rd_busy_low", 32'(sw_busy), 32'd0);
    tick();
    chk("rd_ready_drop", 32'(ready), 32'd0);
    chk("rd_id_hold", 32'(ready_id), 32'h11);

    // Simultaneous acks on sw 0, 1, 4
    issue(0, 1'b0, 8'h01); tick();
    issue(1, 1'b0, 8'h02); tick();
    issue(4, 1'b0, 8'h03); tick();
    set_data(0, 8'h10); set_data(1, 8'h20); set_data(4, 8'h40);
    ack_in = 5'b10011; tick();
    tick(); chk_resp("sim0", 8'h01, 8'h10, 1'b0);
    chk("sim0_busy", 32'(sw_busy), 32'b10010);
    tick(); chk_resp("sim1", 8'h02, 8'h20, 1'b0);
    tick(); chk_resp("sim2", 8'h03, 8'h40, 1'b0);
    chk("sim_busy_clear", 32'(sw_busy), 32'd0);
    tick(); chk("sim_done", 32'(ready), 32'd0);

    // Write timeout on sw 3: ready after edge E+17
    issue(3, 1'b1, 8'h7E); tick();
    for (int k = 1; k <= 16; k++) tick();
    chk("to_not_yet", 32'(ready), 32'd0);
    chk("to_busy", 32'(sw_busy), 32'b01000);
    tick();
    chk_resp("to", 8'h7E, 8'h00, 1'b1);

    // Ack lands on the final timeout cycle: ack wins
    tick();
    issue(3, 1'b0, 8'h33); tick();
    for (int k = 1; k <= 15; k++) tick();
    ack_in = 5'b01000; set_data(3, 8'h5A); tick();
    tick();
    chk_resp("tie", 8'h33, 8'h5A, 1'b0);

    // Protocol violations and same-slot re-issue in the ready cycle
    tick();
    issue(1, 1'b0, 8'h44); tick();
    issue(1, 1'b0, 8'h55); tick();
    chk("busy_ierr", 32'(issue_err), 32'd1);
    tick();
    chk("ierr_pulse", 32'(issue_err), 32'd0);
    issue(6, 1'b0, 8'h66); tick();
    chk("range_ierr", 32'(issue_err), 32'd1);
    ack_in = 5'b00001; tick(); tick();
    chk("idle_ack", 32'(ready), 32'd0);
    ack_in = 5'b00010; set_data(1, 8'h77); tick(); tick();
    chk_resp("keep_id", 8'h44, 8'h77, 1'b0);
    issue(1, 1'b1, 8'h66); tick();
    chk("reissue_ok", 32'(issue_err), 32'd0);
    chk("reissue_busy", 32'(sw_busy), 32'b00010);
    ack_in = 5'b00010; tick(); tick();
    chk_resp("reissue_wr", 8'h66, 8'h00, 1'b0);

    // Ack in the issue cycle is ignored
    issue(0, 1'b0, 8'h12); ack_in = 5'b00001; set_data(0, 8'hEE); tick();
    tick(); tick();
    chk("same_cyc_ack", 32'(ready), 32'd0);
    chk("same_cyc_busy", 32'(sw_busy), 32'b00001);
    ack_in = 5'b00001; set_data(0, 8'h99); tick(); tick();
    chk_resp("late_ack", 8'h12, 8'h99, 1'b0);

    // Reset while sw 0 is DONE and sw 2 is WAIT
    issue(0, 1'b0, 8'h21); tick();
    issue(2, 1'b0, 8'h22); tick();
    ack_in = 5'b00001; tick();
    rst_n = 1'b1; tick();
    rst_n = 1'b0;
    chk("mr_ready", 32'(ready), 32'd0);
    chk("mr_busy", 32'(sw_busy), 32'd0);
    ack_in = 5'b00101; tick(); tick();
    chk("mr_ready2", 32'(ready), 32'd0);
    chk("mr_busy2", 32'(sw_busy), 32'd0);
    chk("mr_id", 32'(ready_id), 32'd0);
    chk("mr_data", 32'(rd_data_out), 32'd0);
    chk("mr_err", 32'(resp_err), 32'd0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_resp_tracker.md
# rx_resp_tracker

Response-side stage of the unit address decoder. It sits directly downstream of the TX scheduler and directly upstream of the host read/ready interface. It tracks at most one outstanding operation per switch instance, waits for that instance's ack or a timeout, captures read data, and returns responses to the host one per cycle with the originating op ID. Per-instance busy flags are fed back to the scheduler so it never issues to an occupied instance.

## Interface
Parameters:
- NUM_SW_INST, 5, number of switch instances (1..8)
- W_WIDTH, 8, data width
- TIMEOUT_CYC, 16, wait cycles before an op is failed; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-high (asserted = 1)
- issue_valid  in  1  scheduler issues an op this cycle
- issue_sw  in  3  target instance index
- issue_wr_rd  in  1  1 = write, 0 = read
- issue_op_id  in  8  op ID of the issued op
- ack_in  in  NUM_SW_INST  per-instance ack, one-cycle pulse
- sw_rd_data  in  NUM_SW_INST*W_WIDTH  per-instance read data; slice i is valid while ack_in[i] = 1
- sw_busy  out  NUM_SW_INST  slot i occupied (WAIT or DONE)
- issue_err  out  1  one-cycle pulse: issue rejected
- ready  out  1  one-cycle response strobe
- ready_id  out  8  op ID of the response
- rd_data_out  out  W_WIDTH  read data; 0 for writes and errors
- resp_err  out  1  response is a timeout; qualified by ready

## Operation
- Each instance i has a slot holding state, op_id, wr_rd, a data register and an 8-bit timeout counter.
- Slot states:
  - IDLE -> WAIT on a valid issue to slot i.
  - WAIT -> DONE on ack_in[i] (capture data, err = 0) or on timeout (data = 0, err = 1).
  - DONE -> IDLE in the cycle the slot's response is emitted.
- sw_busy[i] = 1 in WAIT and DONE; it is driven from registered state.
- Issue to a non-IDLE slot, or with issue_sw >= NUM_SW_INST:
  - slot unchanged;
  - issue_err pulses the next cycle.
- ack_in[i] while slot i is IDLE or DONE is ignored.
- An ack in the same cycle as the issue to that slot is ignored, because the slot is not yet WAIT.
- Write ack: data register captured as 0.
- Timeout:
  - The counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter equals TIMEOUT_CYC-1 with no ack, the slot goes DONE with err at that edge.
  - If an ack and the timeout fall in the same cycle, the ack wins.
- Output arbitration: fixed priority, lowest DONE index first, at most one response per cycle. Other DONE slots hold their data.
- The host side has no backpressure.

## Timing
- Reset: every slot IDLE, counters 0. sw_busy = 0, issue_err = 0, ready = 0, ready_id = 0, rd_data_out = 0, resp_err = 0. Pending responses are dropped.
- Issue sampled at edge E: sw_busy[i] = 1 from E+1.
- Ack sampled at edge A: slot DONE from A+1. If it is the lowest DONE slot, ready = 1 in cycle A+2, and sw_busy[i] = 0 in that same cycle A+2.
- Earliest re-issue to the same slot: the cycle in which ready is high for it. It is accepted because sw_busy falls with that edge and the slot is IDLE.
- Timeout, issued at E with no ack: DONE at E+TIMEOUT_CYC; ready with resp_err = 1 at E+TIMEOUT_CYC+1 if it wins arbitration.
- N slots going DONE together produce responses on N consecutive cycles, in ascending index order.
- ready_id, rd_data_out and resp_err are registered.
  - They hold their last value when ready = 0, except that all three are 0 after reset.
  - rd_data_out and resp_err are don't-care while ready = 0.
- Reset asserted mid-WAIT or mid-DONE: the next cycle is the full reset state and no response is emitted.

## Test plan
- Single read: issue sw=2, id=0x11, read; ack_in[2] 3 cycles later with data 0xA5 -> ready 2 cycles after the ack, ready_id=0x11, rd_data_out=0xA5, resp_err=0, sw_busy[2] low in the same cycle.
- Simultaneous acks: reads outstanding on sw 0, 1 and 4 with ids 0x01, 0x02, 0x03 and data 0x10, 0x20, 0x40; all acked in one cycle -> three consecutive ready pulses, ids 0x01, 0x02, 0x03, with their data.
- Timeout: TIMEOUT_CYC=16, write issued to sw 3 with id 0x7E at edge E, no ack -> ready at E+17 with ready_id=0x7E, rd_data_out=0, resp_err=1.
- Ack vs timeout tie: ack delivered in the cycle the counter hits 15 -> resp_err=0 and the acked data is returned.
- Protocol violations: issue to busy sw 1 -> issue_err pulse, original op_id preserved. Issue to sw=6 with NUM_SW_INST=5 -> issue_err. Ack to an idle slot -> no ready.
- Reset mid-op: reads outstanding on sw 0 and 2, rst_n=1 for one cycle, then acks arrive -> no ready, sw_busy=0, all outputs 0.
